multicycle_controller: RTL and testbench

Control FSM that sequences the shared multicycle RISC-V datapath: one ALU, one memory port, the register file and the immediate generator. It decodes the latched instruction fields and produces, cycle by cycle, the mux selects, write enables, ALU control and `ImmSrc` that drive the datapath. Memory accesses (instruction and data) use a ready handshake, so the same core can sit behind slow memory or the I2C bridge. Supported instructions: lw, sw, R-type ALU, I-type ALU, beq.

---
 rtl/riscv_ctrl_pkg.sv | 61 ++++++
 rtl/alu_decoder.sv | 31 +++
 rtl/multicycle_controller.sv | 151 +++++++++++++++
 tb/tb_multicycle_controller.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control path.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic ADR_PC     = 1'b0;
   localparam logic ADR_ALUOUT = 1'b1;

   // Immediate format depends only on the opcode, so it is valid in every state.
   function automatic logic [1:0] imm_src_of(input logic [6:0] op);
      case (op)
         OP_SW:   return IMM_S;
         OP_BEQ:  return IMM_B;
         default: return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from alu_op and instruction fields.
module alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic       op5,
   input  logic       funct7b5,
   output logic [2:0] alu_control
);

   // funct3 selects the operation only for register/immediate ALU instructions;
   // sub needs op[5] as well, since addi with imm[10]=1 also sets instr[30].
   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the shared multicycle RISC-V datapath.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   FETCH    | read instruction at PC, PC+4 -> PC when memory is ready
//   DECODE   | decode op, compute branch target into ALUOut
//   MEMADR   | rs1 + imm -> ALUOut (load/store address)
//   MEMREAD  | read data memory at ALUOut until ready
//   MEMWB    | write loaded data to rd
//   MEMWRITE | write data memory at ALUOut until ready
//   EXECR    | rs1 op rs2
//   EXECI    | rs1 op imm
//   ALUWB    | write ALUOut to rd
//   BEQ      | rs1 - rs2, take branch on zero
module multicycle_controller
   import riscv_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] imm_src,
   output logic [2:0] alu_control,
   output logic       reg_write,
   output logic       illegal_instr
);

   state_t     state, state_next;
   logic [1:0] alu_op;
   logic       pc_write_raw, ir_write_raw, mem_write_raw, reg_write_raw, illegal_raw;

   // State register; reset aborts any instruction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_FETCH;
      else        state <= state_next;
   end

   // Next-state and Moore output decode.
   always_comb begin
      state_next    = state;
      pc_write_raw  = 1'b0;
      ir_write_raw  = 1'b0;
      mem_write_raw = 1'b0;
      reg_write_raw = 1'b0;
      illegal_raw   = 1'b0;
      adr_src       = ADR_PC;
      result_src    = RES_ALUOUT;
      alu_src_a     = SRCA_PC;
      alu_src_b     = SRCB_RS2;
      alu_op        = ALUOP_ADD;
      case (state)
         S_FETCH: begin
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURESULT;
            if (mem_ready) begin
               ir_write_raw = 1'b1;
               pc_write_raw = 1'b1;
               state_next   = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            case (op)
               OP_LW, OP_SW: state_next = S_MEMADR;
               OP_R:         state_next = S_EXECR;
               OP_I:         state_next = S_EXECI;
               OP_BEQ:       state_next = S_BEQ;
               default: begin
                  illegal_raw = 1'b1;
                  state_next  = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_IMM;
            state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            adr_src = ADR_ALUOUT;
            if (mem_ready) state_next = S_MEMWB;
         end
         S_MEMWB: begin
            result_src    = RES_DATA;
            reg_write_raw = 1'b1;
            state_next    = S_FETCH;
         end
         S_MEMWRITE: begin
            adr_src       = ADR_ALUOUT;
            mem_write_raw = 1'b1;
            if (mem_ready) state_next = S_FETCH;
         end
         S_EXECR: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_RS2;
            alu_op     = ALUOP_FUNCT;
            state_next = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_IMM;
            alu_op     = ALUOP_FUNCT;
            state_next = S_ALUWB;
         end
         S_ALUWB: begin
            result_src    = RES_ALUOUT;
            reg_write_raw = 1'b1;
            state_next    = S_FETCH;
         end
         S_BEQ: begin
            alu_src_a    = SRCA_RS1;
            alu_src_b    = SRCB_RS2;
            alu_op       = ALUOP_SUB;
            result_src   = RES_ALUOUT;
            pc_write_raw = zero;
            state_next   = S_FETCH;
         end
         default: state_next = S_FETCH;
      endcase
   end

   // Reset parks the FSM in FETCH, where mem_ready alone would raise
   // ir_write/pc_write, so every strobe is gated by rst_n.
   assign pc_write      = pc_write_raw  & rst_n;
   assign ir_write      = ir_write_raw  & rst_n;
   assign mem_write     = mem_write_raw & rst_n;
   assign reg_write     = reg_write_raw & rst_n;
   assign illegal_instr = illegal_raw   & rst_n;

   assign imm_src = imm_src_of(op);

   alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .funct3      (funct3),
      .op5         (op[5]),
      .funct7b5    (funct7b5),
      .alu_control (alu_control)
   );

endmodule

// File: tb/tb_multicycle_controller.sv
// Cycle-by-cycle directed check of the multicycle controller outputs.
module tb_multicycle_controller;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] BQ  = 7'b1100011;
   localparam logic [6:0] BAD = 7'b1111111;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] op = LW;
   logic [2:0] funct3 = 3'b000;
   logic       funct7b5 = 1'b0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
   logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
   logic [2:0] alu_control;

   int n_cmp = 0;
   int n_err = 0;

   multicycle_controller dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .op            (op),
      .funct3        (funct3),
      .funct7b5      (funct7b5),
      .zero          (zero),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .adr_src       (adr_src),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .result_src    (result_src),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .imm_src       (imm_src),
      .alu_control   (alu_control),
      .reg_write     (reg_write),
      .illegal_instr (illegal_instr)
   );

   always #5 clk = ~clk;

   // Output bundle: pcw adr mw irw | rs sa sb is | ac | rw ill
   typedef struct {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        f7;
      logic        z;
      logic        mr;
      logic [16:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                      input logic z, input logic mr, input logic [16:0] e);
      vec_t v;
      v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.mr = mr; v.exp = e;
      vecs.push_back(v);
   endtask

   function automatic logic [16:0] outs();
      return {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
              alu_src_b, imm_src, alu_control, reg_write, illegal_instr};
   endfunction

   task automatic check(input string nm, input int idx, input logic [16:0] e);
      logic [16:0] a;
      a = outs();
      n_cmp++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s[%0d]: got %b_%b_%b_%b_%b_%b_%b_%b_%b_%b_%b required %b",
                  nm, idx, a[16], a[15], a[14], a[13], a[12:11], a[10:9], a[8:7],
                  a[6:5], a[4:2], a[1], a[0], e);
      end
   endtask

   // FETCH selects with every strobe forced low, as seen during reset.
   localparam logic [16:0] FETCH_QUIET = 17'b0_0_0_0_10_00_10_00_000_0_0;

   initial begin
      // lw: FETCH DECODE MEMADR MEMREAD MEMWB
      add(LW, 3'b010, 1'b0, 1'b0, 1'b1, 17'b1_0_0_1_10_00_10_00_000_0_0);
      add(LW, 3'b010, 1'b0, 1'b0, 1'b1, 17'b0_0_0_0_00_01_01_00_000_0_0);
      add(LW, 3'b010, 1'b0, 1'b0, 1'b1, 17'b0_0_0_0_00_10_01_00_000_0_0);
      add(LW, 3'b010, 1'b0, 1'b0, 1'b1, 17'b0_1_0_0_00_00_00_00_000_0_0);
      add(LW, 3'b010, 1'b0, 1'b0, 1'b1, 17'b0_0_0_0_01_00_00_00_000_1_0);
      // sw, mem_ready low in DECODE/MEMADR (ignored) and 3 cycles in MEMWRITE
      add(SW, 3'b010, 1'b0, 1'b0, 1'b1, 17'b1_0_0_1_10_00_10_01_000_0_0);
      add(SW, 3'b010, 1'b0, 1'b0, 1'b0, 17'b0_0_0_0_00_01_01_01_000_0_0);
      add(SW, 3'b010, 1'b0, 1'b0, 1'b0, 17'b0_0_0_0_00_10_01_01_000_0_0);
      add(SW, 3'b010, 1'b0, 1'b0, 1'b0, 17'b0_1_1_0_00_00_00_01_000_0_0);
      add(SW, 3'b010, 1'b0, 1'b0, 1'b0, 17'b0_1_1_0_00_00_00_01_000_0_0);
      add(SW, 3'b010, 1'b0, 1'b0, 1'b0, 17'b0_1_1_0_00_00_00_01_000_0_0);
      add(SW, 3'b010, 1'b0, 1'b0, 1'b1, 17'b0_1_1_0_00_00_00_01_000_0_0);
      // sub: one stalled FETCH first
      add(RT, 3'b000, 1'b1, 1'b0, 1'b0, 17'b0_0_0_0_10_00_10_00_000_0_0);
      add(RT, 3'b000, 1'b1, 1'b0, 1'b1, 17'b1_0_0_1_10_00_10_00_000_0_0);
      add(RT, 3'b000, 1'b1, 1'b0, 1'b1, 17'b0_0_0_0_00_01_01_00_000_0_0);
      add(RT, 3'b000, 1'b1, 1'b0, 1'b1, 17'b0_0_0_0_00_10_00_00_001_0_0);
      add(RT, 3'b000, 1'b1, 1'b0, 1'b1, 17'b0_0_0_0_00_00_00_00_000_1_0);
      // add
      add(RT, 3'b000, 1'b0, 1'b0, 1'b1, 17'b1_0_0_1_10_00_10_00_000_0_0);
      add(RT, 3'b000, 1'b0, 1'b0, 1'b1, 17'b0_0_0_0_00_01_01_00_000_0_0);
      add(RT, 3'b000, 1'b0, 1'b0, 1'b1, 17'b0_0_0_0_00_10_00_00_000_0_0);
      add(RT, 3'b000, 1'b0, 1'b0, 1'b1, 17'b0_0_0_0_00_00_00_00_000_1_0);
      // slt
      add(RT, 3'b010, 1'b0, 1'b0, 1'b1, 17'b1_0_0_1_10_00_10_00_000_0_0);
      add(RT, 3'b010, 1'b0, 1'b0, 1'b1, 17'b0_0_0_0_00_01_01_00_000_0_0);
      add(RT, 3'b010, 1'b0, 1'b0, 1'b1, 17'b0_0_0_0_00_10_00_00_101_0_0);
      add(RT, 3'b010, 1'b0, 1'b0, 1'b1, 17'b0_0_0_0_00_00_00_00_000_1_0);
      // and (funct7b5 irrelevant)
      add(RT, 3'b111, 1'b1, 1'b0, 1'b1, 17'b1_0_0_1_10_00_10_00_000_0_0);
      add(RT, 3'b111, 1'b1, 1'b0, 1'b1, 17'b0_0_0_0_00_01_01_00_000_0_0);
      add(RT, 3'b111, 1'b1, 1'b0, 1'b1, 17'b0_0_0_0_00_10_00_00_010_0_0);
      add(RT, 3'b111, 1'b1, 1'b0, 1'b1, 17'b0_0_0_0_00_00_00_00_000_1_0);
      // unsupported funct3 falls back to add
      add(RT, 3'b100, 1'b1, 1'b0, 1'b1, 17'b1_0_0_1_10_00_10_00_000_0_0);
      add(RT, 3'b100, 1'b1, 1'b0, 1'b1, 17'b0_0_0_0_00_01_01_00_000_0_0);
      add(RT, 3'b100, 1'b1, 1'b0, 1'b1, 17'b0_0_0_0_00_10_00_00_000_0_0);
      add(RT, 3'b100, 1'b1, 1'b0, 1'b1, 17'b0_0_0_0_00_00_00_00_000_1_0);
      // addi with instr[30]=1 stays add
      add(IT, 3'b000, 1'b1, 1'b0, 1'b1, 17'b1_0_0_1_10_00_10_00_000_0_0);
      add(IT, 3'b000, 1'b1, 1'b0, 1'b1, 17'b0_0_0_0_00_01_01_00_000_0_0);
      add(IT, 3'b000, 1'b1, 1'b0, 1'b1, 17'b0_0_0_0_00_10_01_00_000_0_0);
      add(IT, 3'b000, 1'b1, 1'b0, 1'b1, 17'b0_0_0_0_00_00_00_00_000_1_0);
      // ori
      add(IT, 3'b110, 1'b0, 1'b0, 1'b1, 17'b1_0_0_1_10_00_10_00_000_0_0);
      add(IT, 3'b110, 1'b0, 1'b0, 1'b1, 17'b0_0_0_0_00_01_01_00_000_0_0);
      add(IT, 3'b110, 1'b0, 1'b0, 1'b1, 17'b0_0_0_0_00_10_01_00_011_0_0);
      add(IT, 3'b110, 1'b0, 1'b0, 1'b1, 17'b0_0_0_0_00_00_00_00_000_1_0);
      // beq taken, mem_ready low outside FETCH
      add(BQ, 3'b000, 1'b0, 1'b1, 1'b1, 17'b1_0_0_1_10_00_10_10_000_0_0);
      add(BQ, 3'b000, 1'b0, 1'b1, 1'b0, 17'b0_0_0_0_00_01_01_10_000_0_0);
      add(BQ, 3'b000, 1'b0, 1'b1, 1'b0, 17'b1_0_0_0_00_10_00_10_001_0_0);
      // beq not taken
      add(BQ, 3'b000, 1'b0, 1'b0, 1'b1, 17'b1_0_0_1_10_00_10_10_000_0_0);
      add(BQ, 3'b000, 1'b0, 1'b0, 1'b1, 17'b0_0_0_0_00_01_01_10_000_0_0);
      add(BQ, 3'b000, 1'b0, 1'b0, 1'b1, 17'b0_0_0_0_00_10_00_10_001_0_0);
      // illegal opcode, then back in FETCH (stalled)
      add(BAD, 3'b000, 1'b0, 1'b0, 1'b1, 17'b1_0_0_1_10_00_10_00_000_0_0);
      add(BAD, 3'b000, 1'b0, 1'b0, 1'b1, 17'b0_0_0_0_00_01_01_00_000_0_1);
      add(LW,  3'b010, 1'b0, 1'b0, 1'b0, 17'b0_0_0_0_10_00_10_00_000_0_0);

      // Reset state with mem_ready high: strobes must stay low.
      mem_ready = 1'b1;
      #2 check("reset_hold", 0, FETCH_QUIET);
      @(posedge clk);
      #1 check("reset_hold", 1, FETCH_QUIET);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         op = vecs[i].op; funct3 = vecs[i].f3; funct7b5 = vecs[i].f7;
         zero = vecs[i].z; mem_ready = vecs[i].mr;
         @(negedge clk);
         check("vec", i, vecs[i].exp);
         @(posedge clk);
         #1;
      end

      // Reset asserted while lw waits in MEMREAD; state is FETCH here.
      op = LW; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 mem_ready = 1'b0;
      @(negedge clk);
      check("in_memread", 0, 17'b0_1_0_0_00_00_00_00_000_0_0);
      #2 rst_n = 1'b0;
      mem_ready = 1'b1;
      #1 check("async_abort", 0, FETCH_QUIET);
      @(posedge clk);
      #1 check("async_abort", 1, FETCH_QUIET);
      @(negedge clk);
      check("async_abort", 2, FETCH_QUIET);
      rst_n = 1'b1;
      #1 check("after_reset", 0, 17'b1_0_0_1_10_00_10_00_000_0_0);
      @(posedge clk);
      #1 check("after_reset", 1, 17'b0_0_0_0_00_01_01_00_000_0_0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
